// File: rtl/debug_tx_arbiter_if.sv
// Handshake bundle between the two byte sources (OCD reply engine, CPU
// serial port), the shared debug UART transmitter and the arbiter.
interface debug_tx_arbiter_if;
  // OCD reply engine side
  logic       ocd_tx_start;
  logic [7:0] ocd_tx_data;
  logic       ocd_frame_active;
  logic       ocd_tx_done;
  logic       ocd_busy;
  // CPU serial port side
  logic       cpu_tx_start;
  logic [7:0] cpu_tx_data;
  logic       cpu_tx_done;
  logic       cpu_busy;
  // Shared transmitter side
  logic       uart_tx_start;
  logic [7:0] uart_tx_data;
  logic       uart_tx_done;
  logic       debug_uart_tx_sel_ocd1_cpu0;
  // Watchdog status
  logic       timeout_clear;
  logic       tx_timeout_flag;

  // Environment: sources, transmitter and status consumer
  modport master (
    output ocd_tx_start, ocd_tx_data, ocd_frame_active,
    output cpu_tx_start, cpu_tx_data,
    output uart_tx_done, timeout_clear,
    input  ocd_tx_done, ocd_busy, cpu_tx_done, cpu_busy,
    input  uart_tx_start, uart_tx_data, debug_uart_tx_sel_ocd1_cpu0,
    input  tx_timeout_flag
  );

  // Arbiter
  modport slave (
    input  ocd_tx_start, ocd_tx_data, ocd_frame_active,
    input  cpu_tx_start, cpu_tx_data,
    input  uart_tx_done, timeout_clear,
    output ocd_tx_done, ocd_busy, cpu_tx_done, cpu_busy,
    output uart_tx_start, uart_tx_data, debug_uart_tx_sel_ocd1_cpu0,
    output tx_timeout_flag
  );
endinterface

// File: rtl/debug_tx_arbiter.sv
// Debug UART TX arbiter: one holding register per source (OCD, CPU),
// alternating tie-break, atomic OCD frames via a frame lock, and a
// no-completion watchdog that forces a completion after TIMEOUT_CYCLES
// WAIT cycles. All outputs come straight from flops.
module debug_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096  // must be >= 2
) (
  input  logic              clk,
  input  logic              sync_reset,
  debug_tx_arbiter_if.slave bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic            SRC_OCD  = 1'b1;
  localparam logic            SRC_CPU  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             ocd_pend_q, ocd_pend_d;
  logic             cpu_pend_q, cpu_pend_d;
  logic [7:0]       ocd_data_q, ocd_data_d;
  logic [7:0]       cpu_data_q, cpu_data_d;
  logic             frame_lock_q, frame_lock_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             uart_tx_start_q, uart_tx_start_d;
  logic [7:0]       uart_tx_data_q, uart_tx_data_d;
  logic             ocd_tx_done_q, ocd_tx_done_d;
  logic             cpu_tx_done_q, cpu_tx_done_d;
  logic             timeout_flag_q, timeout_flag_d;

  logic grant_valid;
  logic grant_ocd;
  logic tx_complete;
  logic tx_timeout;
  logic ocd_accept;
  logic cpu_accept;

  // Grant decision in IDLE: frame lock restricts to OCD, else single pending or alternate on tie
  always_comb begin
    grant_valid = 1'b0;
    grant_ocd   = 1'b0;
    if (state_q != ST_IDLE) begin
      grant_valid = 1'b0;
      grant_ocd   = 1'b0;
    end else if (frame_lock_q) begin
      grant_valid = ocd_pend_q;
      grant_ocd   = 1'b1;
    end else if (ocd_pend_q && cpu_pend_q) begin
      grant_valid = 1'b1;
      grant_ocd   = (last_grant_q == SRC_CPU);
    end else begin
      grant_valid = ocd_pend_q | cpu_pend_q;
      grant_ocd   = ocd_pend_q;
    end
  end

  // Completion sources in WAIT (transmitter done or watchdog expiry) and holding-register accepts
  always_comb begin
    tx_complete = 1'b0;
    tx_timeout  = 1'b0;
    if (state_q == ST_WAIT) begin
      tx_complete = bus.uart_tx_done | (wait_cnt_q == CNT_LAST);
      tx_timeout  = ~bus.uart_tx_done & (wait_cnt_q == CNT_LAST);
    end else begin
      tx_complete = 1'b0;
      tx_timeout  = 1'b0;
    end
    ocd_accept = bus.ocd_tx_start & ~ocd_pend_q;
    cpu_accept = bus.cpu_tx_start & ~cpu_pend_q;
  end

  // Next-state logic of the IDLE/START/WAIT sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_complete) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of holding registers, grant bookkeeping, watchdog and registered outputs
  always_comb begin
    ocd_pend_d      = ocd_pend_q;
    cpu_pend_d      = cpu_pend_q;
    ocd_data_d      = ocd_data_q;
    cpu_data_d      = cpu_data_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    uart_tx_data_d  = uart_tx_data_q;
    uart_tx_start_d = grant_valid;
    ocd_tx_done_d   = tx_complete & (owner_q == SRC_OCD);
    cpu_tx_done_d   = tx_complete & (owner_q == SRC_CPU);

    // A start is only taken into an empty register; the owner is emptied on completion
    if (tx_complete && (owner_q == SRC_OCD)) begin
      ocd_pend_d = 1'b0;
    end else if (ocd_accept) begin
      ocd_pend_d = 1'b1;
      ocd_data_d = bus.ocd_tx_data;
    end else begin
      ocd_pend_d = ocd_pend_q;
    end

    if (tx_complete && (owner_q == SRC_CPU)) begin
      cpu_pend_d = 1'b0;
    end else if (cpu_accept) begin
      cpu_pend_d = 1'b1;
      cpu_data_d = bus.cpu_tx_data;
    end else begin
      cpu_pend_d = cpu_pend_q;
    end

    // Grant loads owner and the byte; owner doubles as the ownership indication
    if (grant_valid) begin
      owner_d        = grant_ocd;
      uart_tx_data_d = grant_ocd ? ocd_data_q : cpu_data_q;
    end else begin
      owner_d        = owner_q;
      uart_tx_data_d = uart_tx_data_q;
    end

    if (tx_complete) begin
      last_grant_d = owner_q;
    end else begin
      last_grant_d = last_grant_q;
    end

    // Lock releases whenever the frame is inactive, even in the cycle of an OCD grant
    if (!bus.ocd_frame_active) begin
      frame_lock_d = 1'b0;
    end else if (grant_valid && grant_ocd) begin
      frame_lock_d = 1'b1;
    end else begin
      frame_lock_d = frame_lock_q;
    end

    // Count WAIT cycles; any other state parks the counter at zero so WAIT starts fresh
    if (state_q == ST_WAIT) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1'b1);
    end else begin
      wait_cnt_d = {CNT_W{1'b0}};
    end

    // A new timeout takes precedence over a simultaneous clear
    if (tx_timeout) begin
      timeout_flag_d = 1'b1;
    end else if (bus.timeout_clear) begin
      timeout_flag_d = 1'b0;
    end else begin
      timeout_flag_d = timeout_flag_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q         <= ST_IDLE;
      ocd_pend_q      <= 1'b0;
      cpu_pend_q      <= 1'b0;
      ocd_data_q      <= 8'h00;
      cpu_data_q      <= 8'h00;
      frame_lock_q    <= 1'b0;
      last_grant_q    <= SRC_CPU;
      owner_q         <= SRC_CPU;
      wait_cnt_q      <= {CNT_W{1'b0}};
      uart_tx_start_q <= 1'b0;
      uart_tx_data_q  <= 8'h00;
      ocd_tx_done_q   <= 1'b0;
      cpu_tx_done_q   <= 1'b0;
      timeout_flag_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      ocd_pend_q      <= ocd_pend_d;
      cpu_pend_q      <= cpu_pend_d;
      ocd_data_q      <= ocd_data_d;
      cpu_data_q      <= cpu_data_d;
      frame_lock_q    <= frame_lock_d;
      last_grant_q    <= last_grant_d;
      owner_q         <= owner_d;
      wait_cnt_q      <= wait_cnt_d;
      uart_tx_start_q <= uart_tx_start_d;
      uart_tx_data_q  <= uart_tx_data_d;
      ocd_tx_done_q   <= ocd_tx_done_d;
      cpu_tx_done_q   <= cpu_tx_done_d;
      timeout_flag_q  <= timeout_flag_d;
    end
  end

  assign bus.ocd_tx_done                 = ocd_tx_done_q;
  assign bus.ocd_busy                    = ocd_pend_q;
  assign bus.cpu_tx_done                 = cpu_tx_done_q;
  assign bus.cpu_busy                    = cpu_pend_q;
  assign bus.uart_tx_start               = uart_tx_start_q;
  assign bus.uart_tx_data                = uart_tx_data_q;
  assign bus.debug_uart_tx_sel_ocd1_cpu0 = owner_q;
  assign bus.tx_timeout_flag             = timeout_flag_q;

endmodule

// File: tb/tb_debug_tx_arbiter.sv
// Bench for debug_tx_arbiter: directed scenarios with literal expectations,
// then randomized traffic, with a per-cycle comparison against a
// transaction-level reference model kept in the bench.
module tb_debug_tx_arbiter;
  localparam int T = 8;

  logic clk;
  logic sync_reset;
  debug_tx_arbiter_if bus ();

  debug_tx_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .sync_reset(sync_reset),
    .bus(bus)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  // Reference model (index 1 = OCD, 0 = CPU)
  logic       m_valid = 1'b0;
  logic [1:0] m_pend;
  logic [7:0] m_data [2];
  logic       m_lock, m_last, m_xfer, m_owner, m_flag;
  int         m_tx_cyc;
  logic       e_ocd_done, e_cpu_done, e_ustart, e_sel;
  logic [7:0] e_udata;
  logic       fin, tmo, g, gocd, oacc, cacc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, then advance the model by one cycle
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("m_ocd_busy", bus.ocd_busy, m_pend[1]);
      check("m_cpu_busy", bus.cpu_busy, m_pend[0]);
      check("m_ocd_done", bus.ocd_tx_done, e_ocd_done);
      check("m_cpu_done", bus.cpu_tx_done, e_cpu_done);
      check("m_uart_start", bus.uart_tx_start, e_ustart);
      check("m_uart_data", bus.uart_tx_data, e_udata);
      check("m_sel", bus.debug_uart_tx_sel_ocd1_cpu0, e_sel);
      check("m_flag", bus.tx_timeout_flag, m_flag);
    end
    if (sync_reset) begin
      m_valid = 1'b1; m_pend = 2'b00; m_lock = 1'b0; m_last = 1'b0;
      m_xfer = 1'b0; m_owner = 1'b0; m_flag = 1'b0;
      e_ocd_done = 1'b0; e_cpu_done = 1'b0; e_ustart = 1'b0;
      e_udata = 8'h00; e_sel = 1'b0;
    end else begin
      fin = 1'b0; tmo = 1'b0; g = 1'b0; gocd = 1'b0;
      // Transfer is in its wait phase on every cycle after the start pulse
      if (m_xfer && cyc > m_tx_cyc) begin
        if (bus.uart_tx_done) fin = 1'b1;
        else if (cyc - m_tx_cyc == T) begin fin = 1'b1; tmo = 1'b1; end
      end
      if (!m_xfer) begin
        if (m_lock) begin g = m_pend[1]; gocd = 1'b1; end
        else if (m_pend == 2'b11) begin g = 1'b1; gocd = ~m_last; end
        else begin g = |m_pend; gocd = m_pend[1]; end
      end
      oacc = bus.ocd_tx_start && !m_pend[1];
      cacc = bus.cpu_tx_start && !m_pend[0];
      e_ocd_done = fin && m_owner;
      e_cpu_done = fin && !m_owner;
      e_ustart   = g;
      if (fin) begin m_pend[m_owner] = 1'b0; m_last = m_owner; m_xfer = 1'b0; end
      if (oacc) begin m_pend[1] = 1'b1; m_data[1] = bus.ocd_tx_data; end
      if (cacc) begin m_pend[0] = 1'b1; m_data[0] = bus.cpu_tx_data; end
      if (g) begin
        m_owner = gocd; m_xfer = 1'b1; m_tx_cyc = cyc + 1;
        e_udata = m_data[gocd]; e_sel = gocd;
      end
      if (!bus.ocd_frame_active) m_lock = 1'b0;
      else if (g && gocd) m_lock = 1'b1;
      if (tmo) m_flag = 1'b1;
      else if (bus.timeout_clear) m_flag = 1'b0;
    end
    cyc++;
  end

  // Advance to the next cycle; pulse inputs drop back to 0
  task automatic step();
    @(posedge clk); #1;
    bus.ocd_tx_start = 1'b0; bus.cpu_tx_start = 1'b0;
    bus.uart_tx_done = 1'b0; bus.timeout_clear = 1'b0; sync_reset = 1'b0;
  endtask

  task automatic do_reset();
    step(); sync_reset = 1'b1; step();
  endtask

  function automatic logic evt(input int which);
    case (which)
      0: return bus.uart_tx_start;
      1: return bus.ocd_tx_done;
      default: return bus.cpu_tx_done;
    endcase
  endfunction

  task automatic wait_evt(input string name, input int which, input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      if (evt(which)) begin at = cyc; break; end
      step();
    end
    if (at < 0) begin
      nchk++; nerr++;
      $display("FAIL %s: no event within %0d cycles", name, max);
    end
  endtask

  task automatic finish_xfer(input int lat);
    repeat (lat) step();
    bus.uart_tx_done = 1'b1;
    step();
  endtask

  task automatic serve(input string name, input logic [7:0] exp);
    int sc;
    wait_evt(name, 0, 40, sc);
    check(name, bus.uart_tx_data, exp);
    finish_xfer(3);
  endtask

  initial begin
    int c0, at, sc, f;
    logic seen77;
    sync_reset = 1'b1;
    bus.ocd_tx_start = 1'b0; bus.ocd_tx_data = 8'h00; bus.ocd_frame_active = 1'b0;
    bus.cpu_tx_start = 1'b0; bus.cpu_tx_data = 8'h00;
    bus.uart_tx_done = 1'b0; bus.timeout_clear = 1'b0;

    // Reset values
    do_reset();
    check("rst_ocd_busy", bus.ocd_busy, 0);
    check("rst_cpu_busy", bus.cpu_busy, 0);
    check("rst_ustart", bus.uart_tx_start, 0);
    check("rst_udata", bus.uart_tx_data, 0);
    check("rst_sel", bus.debug_uart_tx_sel_ocd1_cpu0, 0);
    check("rst_flag", bus.tx_timeout_flag, 0);

    // OCD single byte, done 10 cycles after start (also last WAIT cycle before timeout)
    step(); c0 = cyc;
    bus.ocd_tx_start = 1'b1; bus.ocd_tx_data = 8'hA5;
    step();
    check("t1_busy", bus.ocd_busy, 1);
    wait_evt("t1_ustart", 0, 10, at);
    check("t1_start_lat", at, c0 + 2);
    check("t1_data", bus.uart_tx_data, 8'hA5);
    check("t1_sel", bus.debug_uart_tx_sel_ocd1_cpu0, 1);
    while (cyc < c0 + 10) step();
    bus.uart_tx_done = 1'b1;
    step();
    check("t1_done", bus.ocd_tx_done, 1);
    check("t1_done_cyc", cyc, c0 + 11);
    check("t1_busy_clr", bus.ocd_busy, 0);
    check("t1_no_flag", bus.tx_timeout_flag, 0);

    // Ties: first after reset, after a CPU grant, after an OCD grant
    do_reset();
    bus.ocd_tx_start = 1'b1; bus.ocd_tx_data = 8'h11;
    bus.cpu_tx_start = 1'b1; bus.cpu_tx_data = 8'h22;
    serve("tie1_first", 8'h11);
    serve("tie1_second", 8'h22);
    bus.ocd_tx_start = 1'b1; bus.ocd_tx_data = 8'h33;
    bus.cpu_tx_start = 1'b1; bus.cpu_tx_data = 8'h44;
    serve("tie2_first", 8'h33);
    serve("tie2_second", 8'h44);
    bus.ocd_tx_start = 1'b1; bus.ocd_tx_data = 8'h55;
    serve("solo_ocd", 8'h55);
    bus.ocd_tx_start = 1'b1; bus.ocd_tx_data = 8'h66;
    bus.cpu_tx_start = 1'b1; bus.cpu_tx_data = 8'h69;
    serve("tie3_first", 8'h69);
    serve("tie3_second", 8'h66);

    // Frame lock: 3 OCD bytes go out before the pending CPU byte
    bus.ocd_frame_active = 1'b1;
    bus.ocd_tx_start = 1'b1; bus.ocd_tx_data = 8'hB1;
    step();
    bus.cpu_tx_start = 1'b1; bus.cpu_tx_data = 8'hC1;
    serve("lock_b1", 8'hB1);
    bus.ocd_tx_start = 1'b1; bus.ocd_tx_data = 8'hB2;
    serve("lock_b2", 8'hB2);
    bus.ocd_tx_start = 1'b1; bus.ocd_tx_data = 8'hB3;
    serve("lock_b3", 8'hB3);
    for (int i = 0; i < 3; i++) begin
      check("lock_hold", bus.uart_tx_start, 0);
      step();
    end
    bus.ocd_frame_active = 1'b0; f = cyc;
    wait_evt("lock_release", 0, 10, at);
    check("lock_release_cyc", at, f + 2);
    check("lock_cpu_data", bus.uart_tx_data, 8'hC1);
    finish_xfer(3);

    // Overrun: second CPU start while busy is dropped
    bus.cpu_tx_start = 1'b1; bus.cpu_tx_data = 8'h33;
    step();
    check("ovr_busy", bus.cpu_busy, 1);
    bus.cpu_tx_start = 1'b1; bus.cpu_tx_data = 8'h77;
    serve("ovr_first", 8'h33);
    seen77 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.uart_tx_start && bus.uart_tx_data == 8'h77) seen77 = 1'b1;
      step();
    end
    check("ovr_no_77", seen77, 0);

    // Timeout: no transmitter done at all
    bus.ocd_tx_start = 1'b1; bus.ocd_tx_data = 8'hE1;
    wait_evt("to_ustart", 0, 10, sc);
    wait_evt("to_done", 1, 30, at);
    check("to_done_cyc", at, sc + 1 + 8);
    check("to_flag", bus.tx_timeout_flag, 1);
    bus.ocd_tx_start = 1'b1; bus.ocd_tx_data = 8'hE2;
    wait_evt("to2_ustart", 0, 10, sc);
    while (cyc < sc + 8) step();
    bus.timeout_clear = 1'b1;
    step();
    check("to2_done", bus.ocd_tx_done, 1);
    check("to2_set_wins", bus.tx_timeout_flag, 1);
    bus.timeout_clear = 1'b1;
    step();
    check("to_clear", bus.tx_timeout_flag, 0);

    // Reset in the middle of WAIT
    bus.cpu_tx_start = 1'b1; bus.cpu_tx_data = 8'hD1;
    wait_evt("rw_ustart", 0, 10, sc);
    repeat (3) step();
    sync_reset = 1'b1;
    step();
    check("rw_busy", bus.cpu_busy, 0);
    check("rw_no_done", bus.cpu_tx_done, 0);
    check("rw_no_start", bus.uart_tx_start, 0);
    bus.uart_tx_done = 1'b1;
    step();
    check("rw_late_done", bus.cpu_tx_done, 0);
    step();
    check("rw_idle", bus.uart_tx_start, 0);

    // Randomized traffic checked against the model each cycle
    for (int i = 0; i < 3000; i++) begin
      step();
      bus.ocd_tx_start  = ($urandom_range(0, 3) == 0);
      bus.ocd_tx_data   = 8'($urandom);
      bus.cpu_tx_start  = ($urandom_range(0, 3) == 0);
      bus.cpu_tx_data   = 8'($urandom);
      if ($urandom_range(0, 11) == 0) bus.ocd_frame_active = ~bus.ocd_frame_active;
      bus.uart_tx_done  = ($urandom_range(0, 5) == 0);
      bus.timeout_clear = ($urandom_range(0, 9) == 0);
      sync_reset        = ($urandom_range(0, 299) == 0);
    end
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/debug_tx_arbiter.md
# debug_tx_arbiter

Arbitrates the single debug UART transmitter between two byte sources: the on-chip debugger reply engine (OCD) and the CPU serial port. Each source gets a one-byte holding register. Multi-byte OCD reply frames are transmitted atomically. A no-completion watchdog keeps a silent transmitter from hanging either source. The block sits between the reply engine / CPU UART path and the shared UART TX, and drives the `debug_uart_tx_sel_ocd1_cpu0` ownership indication.

## Interface
- `TIMEOUT_CYCLES`, default 4096: cycles allowed in WAIT without `uart_tx_done` before a forced completion; must be ≥ 2.
- `clk`  in  1  system clock.
- `sync_reset`  in  1  synchronous, active-high reset.
- `ocd_tx_start`  in  1  one-cycle request to send `ocd_tx_data`.
- `ocd_tx_data`  in  8  OCD byte, sampled with `ocd_tx_start`.
- `ocd_frame_active`  in  1  high for the whole OCD reply frame; it requests the frame lock.
- `ocd_tx_done`  out  1  one-cycle pulse when the OCD byte completes.
- `ocd_busy`  out  1  OCD holding register is full.
- `cpu_tx_start`, `cpu_tx_data`, `cpu_tx_done`, `cpu_busy`: same as the OCD equivalents, for the CPU source.
- `uart_tx_start`  out  1  one-cycle start to the shared transmitter.
- `uart_tx_data`  out  8  byte for the transmitter; valid while `uart_tx_start` = 1 and held through WAIT.
- `uart_tx_done`  in  1  transmitter completion pulse.
- `debug_uart_tx_sel_ocd1_cpu0`  out  1  current or last owner (1 = OCD).
- `timeout_clear`  in  1  clears `tx_timeout_flag`.
- `tx_timeout_flag`  out  1  sticky flag: a forced completion occurred.

## Operation
- **Holding registers** (one per source)
  - `xx_tx_start` is accepted only when that source's pending bit = 0. Accepting it latches the data and sets pending.
  - A start while pending = 1 is dropped silently.
  - `xx_busy` = pending.
- **States:** IDLE, START, WAIT.
  - IDLE → START when a source is granted. The grant registers `owner`, `uart_tx_data` and `debug_uart_tx_sel_ocd1_cpu0`.
  - START lasts one cycle with `uart_tx_start` = 1, then goes to WAIT.
  - WAIT → IDLE on `uart_tx_done` or on timeout.
- **Grant rule in IDLE**
  - If `frame_lock` = 1, only OCD may be granted. IDLE waits for the next OCD byte even if CPU is pending.
  - Otherwise, if exactly one source is pending, grant it.
  - Otherwise, if both are pending, grant the source other than `last_grant`.
- **Frame lock**
  - Set when OCD is granted while `ocd_frame_active` = 1.
  - Cleared in any cycle where `ocd_frame_active` = 0.
  - Clear wins over set.
- **Completion**
  - On `uart_tx_done` in WAIT: next cycle, the owner's `xx_tx_done` = 1, the owner's pending is cleared, `last_grant` ← owner, and the state returns to IDLE.
  - `uart_tx_done` outside WAIT is ignored.
- **Timeout**
  - The counter clears on entry to WAIT and increments each WAIT cycle without done.
  - At count = `TIMEOUT_CYCLES`−1 without done, a normal completion is performed (done pulse, pending clear) and `tx_timeout_flag` is set.
- **`timeout_clear`:** clears the flag. Set wins when set and clear coincide.
- **Reset values:**
  - State IDLE; both pending bits 0; `frame_lock` 0.
  - `last_grant` = CPU, so OCD wins the first tie.
  - All pulse outputs 0; `uart_tx_data` 0x00; `debug_uart_tx_sel_ocd1_cpu0` 0; `tx_timeout_flag` 0.
- **Reset mid-transfer:** return to IDLE immediately; pending bits are discarded and no done pulse is issued.

## Timing
- All outputs are registered.
- Start latency: `xx_tx_start` at cycle 0 → `xx_busy` = 1 at cycle 1 → `uart_tx_start` = 1 at cycle 2 (if granted) → WAIT from cycle 3.
- Done latency: `uart_tx_done` at cycle n → `xx_tx_done` = 1 and `xx_busy` = 0 at n+1. The next `uart_tx_start` comes no earlier than n+2.
- `debug_uart_tx_sel_ocd1_cpu0` changes only in the cycle `uart_tx_start` rises and holds between grants.
- Throughput is at most one byte per (transmitter time + 3) cycles.

## Test plan
- **OCD single byte, idle:** `ocd_tx_start` with 0xA5 at cycle 0; `uart_tx_done` 10 cycles after start. Expect `uart_tx_start` at cycle 2 with data 0xA5, `ocd_tx_done` at done+1, and sel = 1.
- **Simultaneous first tie:** both sources start in the same cycle (OCD 0x11, CPU 0x22). Expect the order 0x11 then 0x22. Repeat the tie after a CPU grant: OCD first again. Repeat after an OCD grant: CPU first.
- **Frame lock:** OCD sends 3 bytes with `ocd_frame_active` = 1 while CPU is pending from the start. Expect no CPU byte before all 3 OCD bytes complete. CPU is granted within 2 cycles after `ocd_frame_active` falls.
- **Overrun:** with `cpu_busy` = 1, send a second `cpu_tx_start` with 0x77. Expect 0x77 never to appear on `uart_tx_data`.
- **Timeout:** with `TIMEOUT_CYCLES` = 8, never assert `uart_tx_done`. Expect the done pulse and `tx_timeout_flag` = 1 exactly 8 cycles after entering WAIT. Asserting `timeout_clear` and a timeout in the same cycle leaves the flag at 1.
- **Reset mid-WAIT:** assert `sync_reset` during WAIT. Expect IDLE and `busy` = 0 next cycle, no done pulse, and a later `uart_tx_done` ignored.
